// File: rtl/pe_stream_driver.sv
// pe_stream_driver: drives one SUPER PE from the global buffer.
// After start it pulses pe_en with the latched layer config, then streams
// filter, ifmap and ipsum words through a shared 2-entry prefetch FIFO and
// writes every opsum word back to GLB.
module pe_stream_driver #(
  parameter int DATA_BITS   = 32,
  parameter int ADDR_BITS   = 16,
  parameter int CONFIG_SIZE = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] i_config,
  input  logic [ADDR_BITS-1:0]   filter_base,
  input  logic [ADDR_BITS-1:0]   ifmap_base,
  input  logic [ADDR_BITS-1:0]   ipsum_base,
  input  logic [ADDR_BITS-1:0]   opsum_base,
  output logic                   busy,
  output logic                   done,
  output logic                   glb_rd_en,
  output logic [ADDR_BITS-1:0]   glb_rd_addr,
  input  logic [DATA_BITS-1:0]   glb_rd_data,
  output logic                   glb_wr_en,
  output logic [ADDR_BITS-1:0]   glb_wr_addr,
  output logic [DATA_BITS-1:0]   glb_wr_data,
  output logic                   pe_en,
  output logic [CONFIG_SIZE-1:0] pe_config,
  output logic [DATA_BITS-1:0]   filter,
  output logic [DATA_BITS-1:0]   ifmap,
  output logic [DATA_BITS-1:0]   depthwise_ipsum,
  output logic [DATA_BITS-1:0]   pointwise_ipsum,
  output logic                   filter_valid,
  output logic                   ifmap_valid,
  output logic                   depthwise_ipsum_valid,
  output logic                   pointwise_ipsum_valid,
  input  logic                   filter_ready,
  input  logic                   ifmap_ready,
  input  logic                   depthwise_ipsum_ready,
  input  logic                   pointwise_ipsum_ready,
  input  logic [DATA_BITS-1:0]   opsum,
  input  logic                   opsum_valid,
  output logic                   opsum_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_FILT, S_IFM, S_IPS_DW, S_IPS_PW, S_OPS, S_DONE
  } state_t;

  state_t                 r_state;
  logic [CONFIG_SIZE-1:0] r_pe_config;
  logic [ADDR_BITS-1:0]   r_filt_base;
  logic [ADDR_BITS-1:0]   r_ifm_addr;
  logic [ADDR_BITS-1:0]   r_ips_addr;
  logic [ADDR_BITS-1:0]   r_ops_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pe_en;
  logic                   r_glb_wr_en;
  logic [ADDR_BITS-1:0]   r_glb_wr_addr;
  logic [DATA_BITS-1:0]   r_glb_wr_data;
  logic [4:0]             r_issue_cnt;
  logic [4:0]             r_pop_cnt;
  logic [4:0]             r_col;
  logic                   r_inflight;
  logic [1:0]             r_fifo_cnt;
  logic                   r_fifo_wptr;
  logic                   r_fifo_rptr;
  logic [DATA_BITS-1:0]   r_fifo_mem [2];

  // Layer geometry decoded from the latched config (stored minus one).
  logic [2:0] w_rs, w_p, w_q;
  logic [4:0] w_f;
  logic       w_dw;
  logic [4:0] w_filt_words;
  assign w_rs         = {1'b0, r_pe_config[11:10]} + 3'd1;
  assign w_p          = {1'b0, r_pe_config[8:7]} + 3'd1;
  assign w_q          = {1'b0, r_pe_config[1:0]} + 3'd1;
  assign w_f          = r_pe_config[6:2];
  assign w_dw         = r_pe_config[12];
  assign w_filt_words = 5'(w_rs) * 5'(w_p);

  logic                 w_stream;
  logic                 w_sel_ready;
  logic [4:0]           w_phase_words;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic                 w_fifo_nonempty;
  logic                 w_pop;
  logic [2:0]           w_occ;
  logic                 w_issue;
  logic                 w_last_pop;
  logic                 w_ops_hs;
  logic                 w_ops_last;
  logic [DATA_BITS-1:0] w_head;

  // Per-phase word count, selected ready and read address for the active stream.
  always_comb begin
    w_stream      = 1'b0;
    w_sel_ready   = 1'b0;
    w_phase_words = 5'd0;
    w_rd_addr     = '0;
    case (r_state)
      S_FILT: begin
        w_stream      = 1'b1;
        w_sel_ready   = filter_ready;
        w_phase_words = w_filt_words;
        w_rd_addr     = r_filt_base + ADDR_BITS'(r_issue_cnt);
      end
      S_IFM: begin
        w_stream      = 1'b1;
        w_sel_ready   = ifmap_ready;
        // Column 0 needs the full rs window, later columns slide by one word.
        w_phase_words = (r_col == 5'd0) ? {2'b0, w_rs} : 5'd1;
        w_rd_addr     = r_ifm_addr;
      end
      S_IPS_DW: begin
        w_stream      = 1'b1;
        w_sel_ready   = depthwise_ipsum_ready;
        w_phase_words = w_dw ? {2'b0, w_q} : {2'b0, w_p};
        w_rd_addr     = r_ips_addr;
      end
      S_IPS_PW: begin
        w_stream      = 1'b1;
        w_sel_ready   = pointwise_ipsum_ready;
        w_phase_words = {2'b0, w_p};
        w_rd_addr     = r_ips_addr;
      end
      default: begin
        w_stream      = 1'b0;
      end
    endcase
  end

  // Occupancy counts words in the FIFO plus the read still in flight, so the
  // two entries can never be oversubscribed.
  assign w_fifo_nonempty = (r_fifo_cnt != 2'd0);
  assign w_pop           = w_stream & w_fifo_nonempty & w_sel_ready;
  assign w_occ           = {1'b0, r_fifo_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue         = w_stream & (r_issue_cnt < w_phase_words) & (w_occ < 3'd2);
  assign w_last_pop      = w_pop & (r_pop_cnt == w_phase_words - 5'd1);
  assign w_ops_hs        = (r_state == S_OPS) & opsum_valid;
  assign w_ops_last      = w_ops_hs & (r_pop_cnt == {2'b0, w_p} - 5'd1);
  assign w_head          = r_fifo_mem[r_fifo_rptr];

  assign glb_rd_en   = w_issue;
  assign glb_rd_addr = w_issue ? w_rd_addr : '0;

  assign filter_valid          = (r_state == S_FILT)   & w_fifo_nonempty;
  assign ifmap_valid           = (r_state == S_IFM)    & w_fifo_nonempty;
  assign depthwise_ipsum_valid = (r_state == S_IPS_DW) & w_fifo_nonempty;
  assign pointwise_ipsum_valid = (r_state == S_IPS_PW) & w_fifo_nonempty;
  assign filter                = filter_valid          ? w_head : '0;
  assign ifmap                 = ifmap_valid           ? w_head : '0;
  assign depthwise_ipsum       = depthwise_ipsum_valid ? w_head : '0;
  assign pointwise_ipsum       = pointwise_ipsum_valid ? w_head : '0;
  assign opsum_ready           = (r_state == S_OPS);

  assign busy        = r_busy;
  assign done        = r_done;
  assign pe_en       = r_pe_en;
  assign pe_config   = r_pe_config;
  assign glb_wr_en   = r_glb_wr_en;
  assign glb_wr_addr = r_glb_wr_addr;
  assign glb_wr_data = r_glb_wr_data;

  // Prefetch storage: GLB data lands one cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_mem[r_fifo_wptr] <= glb_rd_data;
    end
  end

  // Job sequencer, prefetch bookkeeping and registered GLB write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pe_config   <= '0;
      r_filt_base   <= '0;
      r_ifm_addr    <= '0;
      r_ips_addr    <= '0;
      r_ops_addr    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pe_en       <= 1'b0;
      r_glb_wr_en   <= 1'b0;
      r_glb_wr_addr <= '0;
      r_glb_wr_data <= '0;
      r_issue_cnt   <= '0;
      r_pop_cnt     <= '0;
      r_col         <= '0;
      r_inflight    <= 1'b0;
      r_fifo_cnt    <= '0;
      r_fifo_wptr   <= 1'b0;
      r_fifo_rptr   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_pe_en     <= 1'b0;
      r_glb_wr_en <= 1'b0;

      // FIFO pointers; push and pop together leave the count unchanged.
      if (r_inflight) r_fifo_wptr <= ~r_fifo_wptr;
      if (w_pop)      r_fifo_rptr <= ~r_fifo_rptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;

      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 5'd1;
        if (r_state == S_IFM) r_ifm_addr <= r_ifm_addr + 1'b1;
        // Ipsum is laid out contiguously: each column is its dw words then pw words.
        if (r_state == S_IPS_DW || r_state == S_IPS_PW) r_ips_addr <= r_ips_addr + 1'b1;
      end
      if (w_pop) r_pop_cnt <= r_pop_cnt + 5'd1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pe_config <= i_config;
            r_filt_base <= filter_base;
            r_ifm_addr  <= ifmap_base;
            r_ips_addr  <= ipsum_base;
            r_ops_addr  <= opsum_base;
            r_busy      <= 1'b1;
            r_pe_en     <= 1'b1;
            r_col       <= '0;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_state     <= S_CFG;
          end
        end
        S_CFG: begin
          r_state <= S_FILT;
        end
        S_FILT: begin
          if (w_last_pop) begin
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_state     <= S_IFM;
          end
        end
        S_IFM: begin
          if (w_last_pop) begin
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_state     <= S_IPS_DW;
          end
        end
        S_IPS_DW: begin
          if (w_last_pop) begin
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_state     <= w_dw ? S_IPS_PW : S_OPS;
          end
        end
        S_IPS_PW: begin
          if (w_last_pop) begin
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_state     <= S_OPS;
          end
        end
        S_OPS: begin
          if (w_ops_hs) begin
            r_glb_wr_en   <= 1'b1;
            r_glb_wr_addr <= r_ops_addr;
            r_glb_wr_data <= opsum;
            r_ops_addr    <= r_ops_addr + 1'b1;
            r_pop_cnt     <= r_pop_cnt + 5'd1;
          end
          if (w_ops_last) begin
            r_pop_cnt <= '0;
            if (r_col == w_f) begin
              r_state <= S_DONE;
            end else begin
              r_col   <= r_col + 5'd1;
              r_state <= S_IFM;
            end
          end
        end
        S_DONE: begin
          // The last write is on the port this cycle; done follows it.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Testbench for pe_stream_driver: GLB model, randomized PE handshakes and a
// scoreboard of expected stream words and GLB writes built from the layer rules.
module tb_pe_stream_driver;
  localparam int DB = 32;
  localparam int AB = 16;
  localparam int CS = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CS-1:0] i_config;
  logic [AB-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic          busy, done;
  logic          glb_rd_en;
  logic [AB-1:0] glb_rd_addr;
  logic [DB-1:0] glb_rd_data = '0;
  logic          glb_wr_en;
  logic [AB-1:0] glb_wr_addr;
  logic [DB-1:0] glb_wr_data;
  logic          pe_en;
  logic [CS-1:0] pe_config;
  logic [DB-1:0] filter, ifmap, depthwise_ipsum, pointwise_ipsum;
  logic          filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid;
  logic          filter_ready = 1'b1, ifmap_ready = 1'b1;
  logic          depthwise_ipsum_ready = 1'b1, pointwise_ipsum_ready = 1'b1;
  logic [DB-1:0] opsum = '0;
  logic          opsum_valid = 1'b0;
  logic          opsum_ready;

  pe_stream_driver #(.DATA_BITS(DB), .ADDR_BITS(AB), .CONFIG_SIZE(CS)) dut (
    .clk(clk), .rst(rst), .start(start), .i_config(i_config),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done),
    .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr), .glb_rd_data(glb_rd_data),
    .glb_wr_en(glb_wr_en), .glb_wr_addr(glb_wr_addr), .glb_wr_data(glb_wr_data),
    .pe_en(pe_en), .pe_config(pe_config),
    .filter(filter), .ifmap(ifmap),
    .depthwise_ipsum(depthwise_ipsum), .pointwise_ipsum(pointwise_ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid),
    .depthwise_ipsum_valid(depthwise_ipsum_valid), .pointwise_ipsum_valid(pointwise_ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready),
    .depthwise_ipsum_ready(depthwise_ipsum_ready), .pointwise_ipsum_ready(pointwise_ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  always #5 clk = ~clk;

  // Expected handshake sequence: port 0..3 = filter/ifmap/dw/pw, 4 = opsum.
  typedef struct packed { logic [2:0] port; logic [AB-1:0] addr; } ev_t;
  typedef struct packed { logic [AB-1:0] addr; logic [DB-1:0] data; } wr_t;
  ev_t ev_q[$];
  wr_t wr_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int inv_err = 0;
  int done_cnt = 0;
  int ops_hs_cnt = 0;
  int dw_hs_cnt = 0;
  logic [31:0] salt = 32'h0;
  bit bp_filter = 1'b0;
  bit bp_all = 1'b0;
  int ops_delay = 0;

  function automatic logic [DB-1:0] glb_word(input logic [AB-1:0] a);
    return ({16'h0, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // GLB read port: data one cycle after the request.
  always @(posedge clk) begin
    if (glb_rd_en) glb_rd_data <= glb_word(glb_rd_addr);
  end

  // PE-side ready generation.
  always @(posedge clk) begin
    #1;
    filter_ready          = (bp_filter || bp_all) ? 1'($urandom_range(0, 1)) : 1'b1;
    ifmap_ready           = bp_all ? 1'($urandom_range(0, 1)) : 1'b1;
    depthwise_ipsum_ready = bp_all ? 1'($urandom_range(0, 1)) : 1'b1;
    pointwise_ipsum_ready = bp_all ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // PE-side opsum producer with a programmable gap after each accepted word.
  int ops_seen = 0;
  int stall = 0;
  always @(posedge clk) begin
    #1;
    if (ops_hs_cnt != ops_seen) begin
      ops_seen    = ops_hs_cnt;
      opsum_valid = 1'b0;
      stall       = ops_delay;
    end
    if (!opsum_valid) begin
      if (stall > 0) stall--;
      else begin
        opsum_valid = 1'b1;
        opsum       = $urandom;
      end
    end
  end

  // Monitor: scoreboard pops on every handshake / write, plus protocol invariants.
  logic [3:0]    m_v, m_r, prev_v, prev_r;
  logic [DB-1:0] m_d [4];
  logic [DB-1:0] prev_d [4];
  int outst = 0;
  int pops;
  ev_t e;
  wr_t w;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = '0;
      prev_r = '0;
      outst  = 0;
    end else begin
      m_v = {pointwise_ipsum_valid, depthwise_ipsum_valid, ifmap_valid, filter_valid};
      m_r = {pointwise_ipsum_ready, depthwise_ipsum_ready, ifmap_ready, filter_ready};
      m_d[0] = filter; m_d[1] = ifmap; m_d[2] = depthwise_ipsum; m_d[3] = pointwise_ipsum;
      if ($countones(m_v) > 1) begin
        inv_err++;
        $display("inv violation: several valids %b", m_v);
      end
      pops = 0;
      for (int i = 0; i < 4; i++) begin
        if (prev_v[i] && !prev_r[i] && (!m_v[i] || m_d[i] !== prev_d[i])) begin
          inv_err++;
          $display("inv violation: port %0d changed while stalled", i);
        end
        if (m_v[i] && m_r[i]) begin
          pops++;
          if (i == 2) dw_hs_cnt++;
          if (ev_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL hs_unexpected: port %0d data %0h, required none", i, m_d[i]);
          end else begin
            e = ev_q.pop_front();
            check("hs_port", 64'(i), 64'(e.port));
            check("hs_data", 64'(m_d[i]), 64'(glb_word(e.addr)));
          end
        end
      end
      outst = outst + int'(glb_rd_en) - pops;
      if (outst > 2 || outst < 0) begin
        inv_err++;
        $display("inv violation: outstanding reads %0d", outst);
      end
      if (opsum_valid && opsum_ready) begin
        ops_hs_cnt++;
        if (ev_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ops_unexpected: opsum %0h, required none", opsum);
        end else begin
          e = ev_q.pop_front();
          check("ops_port", 64'd4, 64'(e.port));
          wr_q.push_back('{addr: e.addr, data: opsum});
        end
      end
      if (glb_wr_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: addr %0h data %0h, required none", glb_wr_addr, glb_wr_data);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr_data", {glb_wr_addr, glb_wr_data}, {w.addr, w.data});
        end
      end
      if (done) done_cnt++;
      prev_v = m_v;
      prev_r = m_r;
      for (int i = 0; i < 4; i++) prev_d[i] = m_d[i];
    end
  end

  function automatic logic [CS-1:0] mk_cfg(input bit dw, input int rs, input int p, input int f, input int q);
    logic [CS-1:0] c;
    c = '0;
    c[12]    = dw;
    c[11:10] = 2'(rs - 1);
    c[8:7]   = 2'(p - 1);
    c[6:2]   = 5'(f);
    c[1:0]   = 2'(q - 1);
    return c;
  endfunction

  // Reference model: expected handshake order and full-rate job length.
  task automatic build_model(input logic [CS-1:0] cfg, input logic [AB-1:0] fb, ib, pb, ob,
                             output int total);
    int p, q, rs, f, n;
    bit dw;
    logic [AB-1:0] ia, pa, oa;
    dw = cfg[12];
    rs = int'(cfg[11:10]) + 1;
    p  = int'(cfg[8:7]) + 1;
    f  = int'(cfg[6:2]);
    q  = int'(cfg[1:0]) + 1;
    ia = ib; pa = pb; oa = ob;
    total = 1 + (p * rs + 2) + 1;
    for (int k = 0; k < p * rs; k++) ev_q.push_back('{port: 3'd0, addr: fb + AB'(k)});
    for (int c = 0; c <= f; c++) begin
      n = (c == 0) ? rs : 1;
      total += (n + 2) + p;
      for (int k = 0; k < n; k++) begin ev_q.push_back('{port: 3'd1, addr: ia}); ia = ia + 1'b1; end
      if (dw) begin
        total += (q + 2) + (p + 2);
        for (int k = 0; k < q; k++) begin ev_q.push_back('{port: 3'd2, addr: pa}); pa = pa + 1'b1; end
        for (int k = 0; k < p; k++) begin ev_q.push_back('{port: 3'd3, addr: pa}); pa = pa + 1'b1; end
      end else begin
        total += p + 2;
        for (int k = 0; k < p; k++) begin ev_q.push_back('{port: 3'd2, addr: pa}); pa = pa + 1'b1; end
      end
      for (int k = 0; k < p; k++) begin ev_q.push_back('{port: 3'd4, addr: oa}); oa = oa + 1'b1; end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    ev_q.delete();
    wr_q.delete();
    rst = 1'b0;
  endtask

  task automatic kick(input logic [CS-1:0] cfg, input logic [AB-1:0] fb, ib, pb, ob);
    @(posedge clk); #1;
    i_config = cfg; filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the job must run on the values latched with start.
    i_config = CS'($urandom);
    filter_base = AB'($urandom); ifmap_base = AB'($urandom);
    ipsum_base = AB'($urandom); opsum_base = AB'($urandom);
    @(negedge clk);
    check("cfg_pe_en", 64'(pe_en), 64'd1);
    check("cfg_pe_config", 64'(pe_config), 64'(cfg));
    check("cfg_busy", 64'(busy), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [CS-1:0] cfg,
                         input logic [AB-1:0] fb, ib, pb, ob,
                         input bit chk_lat, input bit mid_start);
    int total, cyc, d0, e0;
    bit seen;
    salt = $urandom;
    build_model(cfg, fb, ib, pb, ob, total);
    d0 = done_cnt;
    e0 = inv_err;
    kick(cfg, fb, ib, pb, ob);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (mid_start) begin
        start = (cyc == 6);
        i_config = ~cfg;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", tag, cyc);
      do_reset();
    end else begin
      if (chk_lat) check("latency", 64'(cyc), 64'(total));
      check("ev_drained", 64'(ev_q.size()), 64'd0);
      check("wr_drained", 64'(wr_q.size()), 64'd0);
      check("busy_at_done", 64'(busy), 64'd0);
    end
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("invariants", 64'(inv_err - e0), 64'd0);
    check("pe_config_held", 64'(pe_config), 64'(cfg));
    $display("job %s cfg=%h cycles=%0d compared=%0d mismatched=%0d", tag, cfg, cyc, n_cmp, n_err);
  endtask

  logic any_out;
  initial begin
    int total, cyc, d0;
    logic [CS-1:0] cfg;
    rst = 1'b1; start = 1'b0; i_config = '0;
    filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
    @(negedge clk);
    any_out = |{busy, done, glb_rd_en, glb_rd_addr, glb_wr_en, glb_wr_addr, glb_wr_data,
                pe_en, pe_config, filter, ifmap, depthwise_ipsum, pointwise_ipsum,
                filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid, opsum_ready};
    check("reset_outputs_zero", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-depthwise baseline, full rate.
    run_job("baseline", mk_cfg(1'b0, 3, 2, 0, 3), 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, 1'b0);
    // Depthwise, three columns, full rate.
    run_job("depthwise", mk_cfg(1'b1, 3, 4, 2, 2), 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b1, 1'b0);
    // Filter backpressure.
    bp_filter = 1'b1;
    run_job("filter_bp", mk_cfg(1'b1, 4, 4, 1, 3), 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0, 1'b0);
    bp_filter = 1'b0;
    // Opsum stall.
    ops_delay = 5;
    run_job("ops_stall", mk_cfg(1'b0, 2, 3, 2, 1), 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0, 1'b0);
    ops_delay = 0;

    // Reset during the depthwise ipsum phase, then a clean job.
    cfg = mk_cfg(1'b1, 2, 2, 1, 4);
    salt = $urandom;
    build_model(cfg, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, total);
    kick(cfg, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
    d0 = dw_hs_cnt;
    cyc = 0;
    while (dw_hs_cnt == d0 && cyc < 500) begin @(negedge clk); cyc++; end
    check("reached_ips_dw", 64'(dw_hs_cnt != d0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    any_out = |{busy, done, glb_rd_en, glb_rd_addr, glb_wr_en, glb_wr_addr, glb_wr_data,
                pe_en, pe_config, filter, ifmap, depthwise_ipsum, pointwise_ipsum,
                filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid, opsum_ready};
    check("midjob_reset_outputs_zero", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    ev_q.delete();
    wr_q.delete();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
    run_job("after_reset", cfg, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 1'b1, 1'b0);

    // Opsum address wrap with an ignored start while busy.
    run_job("wrap", mk_cfg(1'b0, 2, 2, 0, 2), 16'hFFF0, 16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

    // Randomized jobs with backpressure on every stream and random opsum gaps.
    for (int t = 0; t < 6; t++) begin
      cfg = CS'($urandom);
      cfg[6:2] = 5'($urandom_range(0, 3));
      bp_all = 1'($urandom_range(0, 1));
      ops_delay = $urandom_range(0, 3);
      run_job($sformatf("rand%0d", t), cfg, AB'($urandom), AB'($urandom), AB'($urandom),
              AB'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end
    bp_all = 1'b0;
    ops_delay = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
